// File: rtl/av2_bitstream_fetch.sv
// -----------------------------------------------------------------------------
// av2_bitstream_fetch
//
// Front end of the AV2 decode pipeline. Packs 32-bit bitstream words MSB-first
// into 128-bit beats, buffers the beats in a small FIFO and presents them to the
// entropy decoder with a show-ahead valid/ready handshake. Each beat carries a
// frame-end flag and the count of valid bytes it holds.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of packer, FIFO and word counter
//   in_data/in_valid/in_ready/in_last/in_nbytes_last
//                       upstream word handshake; first byte in in_data[31:24]
//   bitstream_data/bitstream_valid/bitstream_ready/bitstream_last/bitstream_nbytes
//                       downstream beat handshake; word 0 in bitstream_data[127:96]
//   fill_level          beats currently held in the FIFO
//   words_consumed      accepted input words, wraps modulo 2^32
// -----------------------------------------------------------------------------
module av2_bitstream_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2:0]       in_nbytes_last,
  output logic [127:0]     bitstream_data,
  output logic             bitstream_valid,
  input  logic             bitstream_ready,
  output logic             bitstream_last,
  output logic [4:0]       bitstream_nbytes,
  output logic [CNT_W-1:0] fill_level,
  output logic [31:0]      words_consumed
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 128 + 1 + 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } pack_state_e;

  pack_state_e        pack_q;
  logic [95:0]        stage_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        words_q;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic               full_s;
  logic               empty_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               pop_s;
  logic               push_s;
  logic [2:0]         word_bytes_s;
  logic [31:0]        masked_word_s;
  logic [127:0]       beat_data_s;
  logic [4:0]         beat_nbytes_s;
  logic [ENTRY_W-1:0] head_s;

  // Handshake qualifiers; in_ready looks only at registered occupancy and flush.
  always_comb begin
    full_s     = (cnt_q == CNT_W'(FIFO_DEPTH));
    empty_s    = (cnt_q == {CNT_W{1'b0}});
    in_ready_s = !full_s && !flush;
    accept_s   = in_valid && in_ready_s;
    pop_s      = !empty_s && bitstream_ready && !flush;
    push_s     = accept_s && ((pack_q == FILL3) || in_last);
  end

  // Valid bytes of the incoming word; 0 (and out-of-range codes) mean a full word.
  always_comb begin
    word_bytes_s = 3'd4;
    if (in_last) begin
      case (in_nbytes_last)
        3'd1:    word_bytes_s = 3'd1;
        3'd2:    word_bytes_s = 3'd2;
        3'd3:    word_bytes_s = 3'd3;
        default: word_bytes_s = 3'd4;
      endcase
    end else begin
      word_bytes_s = 3'd4;
    end
  end

  // Zero the byte lanes beyond the valid bytes of a short final word.
  always_comb begin
    masked_word_s = in_data;
    case (word_bytes_s)
      3'd1:    masked_word_s = {in_data[31:24], 24'h000000};
      3'd2:    masked_word_s = {in_data[31:16], 16'h0000};
      3'd3:    masked_word_s = {in_data[31:8], 8'h00};
      default: masked_word_s = in_data;
    endcase
  end

  // Assemble the beat being pushed: staged words followed by the current word.
  // Unused staging slots are always zero, so trailing lanes come out clear.
  always_comb begin
    beat_data_s   = 128'd0;
    beat_nbytes_s = {1'b0, pack_q, 2'b00} + {2'b00, word_bytes_s};
    case (pack_q)
      EMPTY:   beat_data_s = {masked_word_s, 96'd0};
      FILL1:   beat_data_s = {stage_q[95:64], masked_word_s, 64'd0};
      FILL2:   beat_data_s = {stage_q[95:32], masked_word_s, 32'd0};
      FILL3:   beat_data_s = {stage_q, masked_word_s};
      default: beat_data_s = 128'd0;
    endcase
  end

  // Packer FSM and staging register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= EMPTY;
      stage_q <= 96'd0;
    end else if (flush) begin
      pack_q  <= EMPTY;
      stage_q <= 96'd0;
    end else if (accept_s) begin
      if (push_s) begin
        pack_q  <= EMPTY;
        stage_q <= 96'd0;
      end else begin
        case (pack_q)
          EMPTY: begin
            pack_q          <= FILL1;
            stage_q[95:64]  <= in_data;
          end
          FILL1: begin
            pack_q          <= FILL2;
            stage_q[63:32]  <= in_data;
          end
          FILL2: begin
            pack_q          <= FILL3;
            stage_q[31:0]   <= in_data;
          end
          default: begin
            pack_q  <= EMPTY;
            stage_q <= 96'd0;
          end
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {beat_data_s, in_last, beat_nbytes_s};
    end
  end

  // FIFO pointers, occupancy and accepted-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      words_q  <= 32'd0;
    end else if (flush) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      words_q  <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (accept_s) begin
        words_q <= words_q + 32'd1;
      end
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (empty_s) begin
      bitstream_data   = 128'd0;
      bitstream_last   = 1'b0;
      bitstream_nbytes = 5'd0;
    end else begin
      bitstream_data   = head_s[ENTRY_W-1 -: 128];
      bitstream_last   = head_s[5];
      bitstream_nbytes = head_s[4:0];
    end
  end

  assign bitstream_valid = !empty_s;
  assign in_ready        = in_ready_s;
  assign fill_level      = cnt_q;
  assign words_consumed  = words_q;

endmodule

// File: tb/tb_av2_bitstream_fetch.sv
// Scoreboard bench for av2_bitstream_fetch: directed stimulus pushes the
// hand-computed beats it expects; a monitor pops and compares on every
// output handshake.
module tb_av2_bitstream_fetch;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [2:0]       in_nbytes_last;
  logic [127:0]     bitstream_data;
  logic             bitstream_valid;
  logic             bitstream_ready;
  logic             bitstream_last;
  logic [4:0]       bitstream_nbytes;
  logic [CNT_W-1:0] fill_level;
  logic [31:0]      words_consumed;

  int tests_run = 0;
  int tests_failed = 0;
  logic [133:0] sb [$];

  av2_bitstream_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_nbytes_last(in_nbytes_last),
    .bitstream_data(bitstream_data), .bitstream_valid(bitstream_valid),
    .bitstream_ready(bitstream_ready), .bitstream_last(bitstream_last),
    .bitstream_nbytes(bitstream_nbytes), .fill_level(fill_level),
    .words_consumed(words_consumed)
  );

  always #5 clk = ~clk;

  function automatic logic [133:0] mk(input logic [127:0] d, input logic l, input logic [4:0] n);
    return {d, l, n};
  endfunction

  // Monitor: a pop happens at the next rising edge; compare it against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !flush && bitstream_valid && bitstream_ready) begin
      logic [133:0] exp_v;
      logic [133:0] act_v;
      act_v = {bitstream_data, bitstream_last, bitstream_nbytes};
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL beat_unexpected got %h expected none", act_v);
      end else begin
        exp_v = sb.pop_front();
        if (act_v !== exp_v) begin
          tests_failed++;
          $display("FAIL beat got %h expected %h", act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n);
    bit done = 1'b0;
    in_data = d; in_last = l; in_nbytes_last = n; in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_nbytes_last = 3'd0;
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout word %h not accepted", d);
    end
  endtask

  // Wait (bounded) for the FIFO to empty, then require the scoreboard empty too.
  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (fill_level == 3'd0) done = 1'b1;
    end
    chk({name, "_drained"}, {127'd0, done}, 128'd1);
    chk({name, "_sb_empty"}, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_data = 32'd0; in_valid = 1'b0;
    in_last = 1'b0; in_nbytes_last = 3'd0; bitstream_ready = 1'b1;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream: two words staged, then async reset.
    send(32'hDEADBEEF, 1'b0, 3'd0);
    send(32'hCAFEF00D, 1'b0, 3'd0);
    rst_n = 1'b0; #1;
    chk("rst_valid", {127'd0, bitstream_valid}, 128'd0);
    chk("rst_data", bitstream_data, 128'd0);
    chk("rst_fill", 128'(fill_level), 128'd0);
    chk("rst_words", 128'(words_consumed), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // One full beat.
    sb.push_back(mk(128'h11111111_22222222_33333333_44444444, 1'b0, 5'd16));
    send(32'h11111111, 1'b0, 3'd0);
    send(32'h22222222, 1'b0, 3'd0);
    send(32'h33333333, 1'b0, 3'd0);
    send(32'h44444444, 1'b0, 3'd0);
    chk("latency_valid", {127'd0, bitstream_valid}, 128'd1);
    chk("words_4", 128'(words_consumed), 128'd4);
    drain("beat1");

    // Partial last beat.
    sb.push_back(mk(128'h55555555_66666666_77777777_88888888, 1'b0, 5'd16));
    sb.push_back(mk(128'h99999999_AAAA0000_00000000_00000000, 1'b1, 5'd6));
    send(32'h55555555, 1'b0, 3'd0);
    send(32'h66666666, 1'b0, 3'd0);
    send(32'h77777777, 1'b0, 3'd0);
    send(32'h88888888, 1'b0, 3'd0);
    send(32'h99999999, 1'b0, 3'd0);
    send(32'hAAAAAAAA, 1'b1, 3'd2);
    chk("words_10", 128'(words_consumed), 128'd10);
    drain("partial");

    // Backpressure: fill the FIFO, hold a 17th word (last, nbytes code 0 = 4).
    bitstream_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      sb.push_back(mk({32'hB0000000 + 32'(4*j), 32'hB0000000 + 32'(4*j+1),
                       32'hB0000000 + 32'(4*j+2), 32'hB0000000 + 32'(4*j+3)}, 1'b0, 5'd16));
    end
    sb.push_back(mk({32'hB0000010, 96'd0}, 1'b1, 5'd4));
    for (int i = 0; i < 16; i++) send(32'hB0000000 + 32'(i), 1'b0, 3'd0);
    chk("full_fill", 128'(fill_level), 128'd4);
    chk("full_in_ready", {127'd0, in_ready}, 128'd0);
    in_data = 32'hB0000010; in_last = 1'b1; in_nbytes_last = 3'd0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("held_in_ready", {127'd0, in_ready}, 128'd0);
    chk("held_words", 128'(words_consumed), 128'd26);
    chk("held_fill", 128'(fill_level), 128'd4);
    bitstream_ready = 1'b1;
    @(posedge clk); #1;
    chk("pop1_fill", 128'(fill_level), 128'd3);
    chk("pop1_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("extra_words", 128'(words_consumed), 128'd27);
    chk("extra_fill", 128'(fill_level), 128'd3);
    drain("backpressure");

    // Simultaneous push and pop at fill_level 2.
    bitstream_ready = 1'b0;
    sb.push_back(mk(128'hD0000000_D0000001_D0000002_D0000003, 1'b0, 5'd16));
    sb.push_back(mk(128'hD0000004_D0000005_D0000006_D0000007, 1'b0, 5'd16));
    sb.push_back(mk(128'hD0000008_D0000009_D000000A_D000000B, 1'b0, 5'd16));
    for (int i = 0; i < 11; i++) send(32'hD0000000 + 32'(i), 1'b0, 3'd0);
    chk("pp_fill_before", 128'(fill_level), 128'd2);
    in_data = 32'hD000000B; in_valid = 1'b1; bitstream_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pp_fill_after", 128'(fill_level), 128'd2);
    chk("pp_words", 128'(words_consumed), 128'd39);
    drain("pushpop");

    // Flush mid-pack with a word offered in the flush cycle.
    send(32'hE0E0E0E0, 1'b0, 3'd0);
    send(32'hE1E1E1E1, 1'b0, 3'd0);
    flush = 1'b1; in_data = 32'hE2E2E2E2; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_words", 128'(words_consumed), 128'd0);
    chk("flush_fill", 128'(fill_level), 128'd0);
    sb.push_back(mk(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3, 1'b0, 5'd16));
    send(32'hC0C0C0C0, 1'b0, 3'd0);
    send(32'hC1C1C1C1, 1'b0, 3'd0);
    send(32'hC2C2C2C2, 1'b0, 3'd0);
    send(32'hC3C3C3C3, 1'b0, 3'd0);
    chk("post_flush_words", 128'(words_consumed), 128'd4);
    drain("flush");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
